// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ALU operand selection with priority forwarding from
// NUM_FWD later pipeline stages, hazard stall on pending producers, and a
// single-entry ID/EX operand register with valid/ready handshakes.
// Optional macro ALU_OPERAND_PERF_EN adds stall_count and fwd_count ports.
module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_AW-1:0]         rs1_addr,
  input  logic [REG_AW-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [XLEN-1:0]           imm_data,
  input  logic [XLEN-1:0]           pc,
  input  logic [1:0]                a_sel,
  input  logic                      b_sel,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           alu_a,
  output logic [XLEN-1:0]           alu_b,
  output logic [XLEN-1:0]           store_data,
`ifdef ALU_OPERAND_PERF_EN
  output logic [31:0]               stall_count,
  output logic [31:0]               fwd_count,
`endif
  output logic                      hazard_stall
);

  // Returns {pending, value}. Scanning from the oldest source down lets the
  // youngest match overwrite, so index 0 wins. x0 is forced to zero last so
  // it can never forward or stall.
  function automatic logic [XLEN:0] resolve(
    input logic [REG_AW-1:0]         rs,
    input logic [XLEN-1:0]           rf,
    input logic [NUM_FWD-1:0]        v,
    input logic [NUM_FWD-1:0]        p,
    input logic [NUM_FWD*REG_AW-1:0] a,
    input logic [NUM_FWD*XLEN-1:0]   d
  );
    logic [XLEN:0] res;
    res = {1'b0, rf};
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (v[i] && (a[i*REG_AW +: REG_AW] == rs)) res = {p[i], d[i*XLEN +: XLEN]};
    end
    if (rs == '0) res = '0;
    return res;
  endfunction

  logic [XLEN:0]   w_rs1_res;
  logic [XLEN:0]   w_rs2_res;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_fire;

  logic            r_vld_p1;
  logic [XLEN-1:0] r_alu_a_p1;
  logic [XLEN-1:0] r_alu_b_p1;
  logic [XLEN-1:0] r_store_p1;

  assign w_rs1_res = resolve(rs1_addr, rs1_data, fwd_valid, fwd_pending, fwd_addr, fwd_data);
  assign w_rs2_res = resolve(rs2_addr, rs2_data, fwd_valid, fwd_pending, fwd_addr, fwd_data);

  // rs2 is always checked: store_data needs it even when b_sel picks imm.
  assign hazard_stall = in_valid && (w_rs1_res[XLEN] || w_rs2_res[XLEN]);
  assign in_ready     = (!r_vld_p1 || out_ready) && !hazard_stall;
  assign w_fire       = in_valid && in_ready;

  // Operand A mux; the reserved encoding 3 aliases rs1.
  always_comb begin
    w_op_a = w_rs1_res[XLEN-1:0];
    case (a_sel)
      2'd1:    w_op_a = pc;
      2'd2:    w_op_a = '0;
      default: w_op_a = w_rs1_res[XLEN-1:0];
    endcase
  end

  assign w_op_b = b_sel ? imm_data : w_rs2_res[XLEN-1:0];

  // ---- stage p1: ID/EX operand register (flush > fire > drain > hold) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_alu_a_p1 <= '0;
      r_alu_b_p1 <= '0;
      r_store_p1 <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_fire) begin
      r_vld_p1   <= 1'b1;
      r_alu_a_p1 <= w_op_a;
      r_alu_b_p1 <= w_op_b;
      r_store_p1 <= w_rs2_res[XLEN-1:0];
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = r_vld_p1;
  assign alu_a      = r_alu_a_p1;
  assign alu_b      = r_alu_b_p1;
  assign store_data = r_store_p1;

`ifdef ALU_OPERAND_PERF_EN
  function automatic logic fwd_hit(
    input logic [REG_AW-1:0]         rs,
    input logic [NUM_FWD-1:0]        v,
    input logic [NUM_FWD*REG_AW-1:0] a
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (v[i] && (a[i*REG_AW +: REG_AW] == rs)) hit = 1'b1;
    end
    return hit && (rs != '0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic        w_used_fwd;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  // A forwarded rs1 only counts when operand A actually selects rs1.
  assign w_used_fwd = fwd_hit(rs2_addr, fwd_valid, fwd_addr) ||
                      (fwd_hit(rs1_addr, fwd_valid, fwd_addr) && (a_sel[0] == a_sel[1]));

  // Saturating event counters; a flushed fire is not a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (hazard_stall && !flush)         r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_fire && !flush && w_used_fwd) r_fwd_cnt   <= sat_inc(r_fwd_cnt);
    end
  end

  assign stall_count = r_stall_cnt;
  assign fwd_count   = r_fwd_cnt;
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised successor to the ALU operand muxes. Selects both ALU operands, resolves data hazards by priority forwarding from NUM_FWD later pipeline stages, and registers the result into a single-entry ID/EX operand register with valid/ready handshakes. Sits between register-file read and the ALU. Stalls decode when a needed producer result is still pending, e.g. load-use.

Parameters:
XLEN, 32, operand/data width in bits
NUM_FWD, 3, number of forwarding sources; index 0 = youngest stage, highest priority
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
rs1_addr  in  REG_AW  source register 1 index
rs2_addr  in  REG_AW  source register 2 index
rs1_data  in  XLEN  register-file value for rs1
rs2_data  in  XLEN  register-file value for rs2
imm_data  in  XLEN  decoded immediate
pc  in  XLEN  instruction PC
a_sel  in  2  operand A: 0 = rs1, 1 = pc, 2 = zero, 3 = rs1 (reserved)
b_sel  in  1  operand B: 0 = rs2, 1 = imm_data
fwd_valid  in  NUM_FWD  source i holds a register write
fwd_pending  in  NUM_FWD  source i write value not yet available
fwd_addr  in  NUM_FWD*REG_AW  destination index of source i, packed, i at LSBs
fwd_data  in  NUM_FWD*XLEN  write value of source i, packed
flush  in  1  kill the registered operand
out_valid  out  1  alu_a/alu_b/store_data valid
out_ready  in  1  ALU consumes this cycle
alu_a  out  XLEN  registered operand A
alu_b  out  XLEN  registered operand B
store_data  out  XLEN  registered forwarded rs2, independent of b_sel
hazard_stall  out  1  combinational: stalled on a pending producer

Behaviour:
- Reset (rst_n low, async): out_valid=0; alu_a, alu_b, store_data = 0. Counters cleared (see optional feature).
- Forwarding per source operand rs in {rs1, rs2}:
  - match_i = fwd_valid[i] && fwd_addr[i]==rs && rs!=0.
  - Lowest matching i wins. No match gives register-file data.
  - rs==0 always yields 0, never forwarded, never stalls.
- Hazard:
  - hazard_stall = in_valid && (winning match of rs1 or rs2 has fwd_pending set).
  - A pending source with lower priority than a non-pending winner is ignored.
  - rs2 is checked even when b_sel=1, because store_data needs it.
- in_ready = (!out_valid || out_ready) && !hazard_stall. Fire = in_valid && in_ready.
- Latency: 1 cycle. Operands selected from same-cycle forwarding inputs, visible next cycle.
- Register update per clock edge, in priority order:
  1. flush: out_valid<=0, data registers hold, input not captured even if fire.
  2. fire: capture operands, out_valid<=1.
  3. out_valid && out_ready (no fire): out_valid<=0.
  4. Otherwise hold all values.
- Back-to-back: out_ready=1 with continuous in_valid and no hazard gives full throughput, one op per cycle.
- Outputs stay stable while out_valid=1 and out_ready=0. A forwarding change during the hold does not alter them.
- Reset mid-operation: any held operand is discarded. No capture until rst_n deasserts.
- Widths: all paths are pure selection, no arithmetic. a_sel=3 behaves exactly as 0.

Optional Feature:
Macro ALU_OPERAND_PERF_EN.
- Defined:
  - Adds output port stall_count (32 bits): increments each cycle hazard_stall=1 and flush=0, saturating at 0xFFFFFFFF.
  - Adds output port fwd_count (32 bits): increments once per fire in which either operand used a forwarded value, saturating.
  - Both counters reset to 0 by rst_n.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-hold with out_valid=1 -> out_valid=0 and alu_a=alu_b=store_data=0 immediately, without waiting for a clock edge.
- Priority forwarding: rs1=5, fwd0 addr 5 data 0xAAAA, fwd2 addr 5 data 0xBBBB, a_sel=0 -> alu_a=0xAAAA next cycle.
- x0 guard: rs1=0, fwd0 addr 0 data 0x1234 valid and pending -> alu_a=0, hazard_stall=0, in_ready=1.
- Load-use: rs2=7, b_sel=1, fwd0 addr 7 pending for 2 cycles, then data 0x55 -> in_ready=0 for 2 cycles; then capture with alu_b=imm_data and store_data=0x55. Under ALU_OPERAND_PERF_EN: stall_count=2, fwd_count=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and outputs unchanged; then out_ready=1 -> new op appears on the next cycle.
- Flush vs fire: flush=1 and fire in the same cycle -> out_valid=0 next cycle and the new op is dropped.
